windowed_register_file: RTL and testbench
=========================================

Name: windowed_register_file

Overview:
- Parametrised successor to the fixed register file in the SPARC data path.
- Holds 8 globals plus NWINDOWS overlapping 16-register windows, and owns the CWP register.
- Executes SAVE/RESTORE window rotation and checks WIM, raising overflow/underflow trap pulses to the control unit.
- Feeds ALU operand muxes A/B; written from ALU result.

Parameters:
NWINDOWS, 8, number of register windows (legal 2..32)
DATA_W, 32, register data width in bits

Ports:
Clock  input  1  system clock; all state changes on rising edge
Reset  input  1  asynchronous, active-low reset
RA_Sel  input  5  architectural register for read port A
RB_Sel  input  5  architectural register for read port B
RD_Sel  input  5  architectural destination register
Wr_Data  input  DATA_W  write data (ALU result)
RF_Ld  input  1  write enable
Save  input  1  SAVE request: rotate to CWP-1
Restore  input  1  RESTORE request: rotate to CWP+1
CWP_Ld  input  1  load CWP directly (WRPSR path)
CWP_In  input  5  value for CWP_Ld
WIM_In  input  NWINDOWS  window invalid mask, from WIM register
RA_Out  output  DATA_W  read data port A
RB_Out  output  DATA_W  read data port B
CWP  output  5  current window pointer
Win_Overflow  output  1  one-cycle pulse: SAVE into invalid window
Win_Underflow  output  1  one-cycle pulse: RESTORE into invalid window

Behaviour:
- Storage: 8 + 16*NWINDOWS physical registers, each DATA_W bits.
- Physical register 0 always reads 0. Writes to r0 are discarded.
- Address map:
  - r1..r7 map to physical 1..7 (globals).
  - r8..r31: k = r-8; physical = 8 + ((CWP*16 + k) mod (16*NWINDOWS)).
  - Consequence: ins of window w are the same physical registers as outs of window w+1. The last window's ins wrap to window 0's outs.
- Reads: combinational from the array using the current CWP. There is no write bypass; a value written at edge N is visible after edge N.
- Write: at the rising edge when RF_Ld=1. The address is computed from the CWP before any same-edge CWP change.
- Window control, evaluated at the rising edge in priority order:
  1. CWP_Ld=1: if CWP_In < NWINDOWS, CWP <= CWP_In; otherwise CWP is unchanged. Save and Restore are ignored this cycle, and no trap pulse is raised.
  2. Save=1 and Restore=1 together: no-op, no trap.
  3. Save=1: new = CWP-1, wrapping 0 to NWINDOWS-1.
     - WIM_In[new]=1: CWP unchanged; Win_Overflow=1 for exactly the next cycle.
     - Otherwise CWP <= new.
  4. Restore=1: new = CWP+1, wrapping NWINDOWS-1 to 0.
     - WIM_In[new]=1: CWP unchanged; Win_Underflow=1 for the next cycle.
     - Otherwise CWP <= new.
- Trap pulses are registered outputs; each deasserts after one cycle unless re-triggered.
- Back-to-back Save on consecutive cycles each step CWP once, with the WIM check against the updated CWP.
- Reset (Reset=0, asynchronous):
  - CWP=0, Win_Overflow=0, Win_Underflow=0.
  - Register array contents are not cleared; r0 still reads 0.
  - Reset asserted mid-operation aborts any pending Save/Restore effect.
  - The first rising edge after Reset deasserts behaves normally.
- CWP bits above log2(NWINDOWS) always read 0.

Test Plan:
- Reset pulse low mid-run with CWP=5 -> CWP=0 and trap outputs 0 immediately, without waiting for a Clock edge. Write r3=0xDEADBEEF then read RA_Sel=3 -> 0xDEADBEEF. Write r0=0x1234 -> RA_Sel=0 reads 0.
- Window overlap, NWINDOWS=8, CWP=3, WIM=0: write r8 (out) = 0xAAAA0001, then Save -> CWP=2 and r24 (in) reads 0xAAAA0001. Restore -> CWP=3 and r8 reads 0xAAAA0001.
- Wrap, NWINDOWS=8, CWP=0, WIM=0: Save -> CWP=7. Write r24=0x55 at CWP=7, Restore -> CWP=0 and r8 reads 0x55.
- Overflow, CWP=1, WIM=0x01: Save -> CWP stays 1; Win_Overflow high exactly one cycle. Underflow, CWP=6, WIM=0x80: Restore -> CWP 6, Win_Underflow one cycle.
- Priority, CWP=4:
  - Save+Restore together -> CWP 4, no pulse.
  - CWP_Ld=1, CWP_In=2, Save=1 -> CWP 2, no pulse.
  - CWP_Ld=1, CWP_In=9 (NWINDOWS=8) -> CWP 4.
- Same-edge write and Save, CWP=3: RF_Ld=1, RD_Sel=16, Wr_Data=0x77 with Save=1 -> value lands in window 3 locals. After Restore, r16 reads 0x77; at CWP=2, r16 reads a different register. Repeat at NWINDOWS=3 and 32.

Source files
------------

// File: rtl/windowed_register_file_if.sv
// Interface for the windowed register file.
// Groups operand select, write, window control, WIM, read data, CWP and trap pulse signals.
interface windowed_register_file_if #(
    parameter int NWINDOWS = 8,
    parameter int DATA_W   = 32
);
    logic [4:0]          RA_Sel;
    logic [4:0]          RB_Sel;
    logic [4:0]          RD_Sel;
    logic [DATA_W-1:0]   Wr_Data;
    logic                RF_Ld;
    logic                Save;
    logic                Restore;
    logic                CWP_Ld;
    logic [4:0]          CWP_In;
    logic [NWINDOWS-1:0] WIM_In;
    logic [DATA_W-1:0]   RA_Out;
    logic [DATA_W-1:0]   RB_Out;
    logic [4:0]          CWP;
    logic                Win_Overflow;
    logic                Win_Underflow;

    modport master (
        output RA_Sel, RB_Sel, RD_Sel, Wr_Data, RF_Ld,
        output Save, Restore, CWP_Ld, CWP_In, WIM_In,
        input  RA_Out, RB_Out, CWP, Win_Overflow, Win_Underflow
    );

    modport slave (
        input  RA_Sel, RB_Sel, RD_Sel, Wr_Data, RF_Ld,
        input  Save, Restore, CWP_Ld, CWP_In, WIM_In,
        output RA_Out, RB_Out, CWP, Win_Overflow, Win_Underflow
    );
endinterface

// File: rtl/windowed_register_file.sv
// SPARC-style windowed register file: 8 globals + NWINDOWS overlapping 16-reg windows, CWP, WIM traps.
// Ports: Clock, Reset (async active-low), bus (slave): selects, write, Save/Restore/CWP_Ld, reads, CWP, traps.
module windowed_register_file #(
    parameter int NWINDOWS = 8,
    parameter int DATA_W   = 32
) (
    input  logic                     Clock,
    input  logic                     Reset,
    windowed_register_file_if.slave  bus
);
    localparam int NREGS = 8 + 16 * NWINDOWS;
    localparam int PW    = $clog2(NREGS);
    localparam int CW    = $clog2(NWINDOWS);
    localparam logic [31:0] WSPAN = 32'(16 * NWINDOWS);
    localparam logic [CW-1:0] WLAST = CW'(NWINDOWS - 1);

    logic [DATA_W-1:0] regs [NREGS];
    logic [CW-1:0]     cwp_q, cwp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [CW-1:0]     dec, inc;
    logic              do_ld, do_sv, do_rs;

    // Architectural to physical mapping; window span wraps so the last
    // window's ins alias window 0's outs.
    function automatic logic [PW-1:0] phys(
        input logic [4:0]    sel,
        input logic [CW-1:0] w
    );
        logic [31:0] off;
        off = 32'(w) * 32'd16 + 32'(sel) - 32'd8;
        if (off >= WSPAN) off = off - WSPAN;
        if (sel < 5'd8) return PW'(sel);
        return PW'(off + 32'd8);
    endfunction

    assign bus.RA_Out = (bus.RA_Sel == 5'd0) ? '0 : regs[phys(bus.RA_Sel, cwp_q)];
    assign bus.RB_Out = (bus.RB_Sel == 5'd0) ? '0 : regs[phys(bus.RB_Sel, cwp_q)];
    assign bus.CWP           = 5'(cwp_q);
    assign bus.Win_Overflow  = ovf_q;
    assign bus.Win_Underflow = unf_q;

    // Array is intentionally not reset; r0 is masked on read.
    always_ff @(posedge Clock) begin
        if (bus.RF_Ld && bus.RD_Sel != 5'd0)
            regs[phys(bus.RD_Sel, cwp_q)] <= bus.Wr_Data;
    end

    assign dec = (cwp_q == '0)   ? WLAST : cwp_q - CW'(1);
    assign inc = (cwp_q == WLAST) ? '0   : cwp_q + CW'(1);

    // Mutually exclusive request terms; Save+Restore together is a no-op.
    assign do_ld = bus.CWP_Ld;
    assign do_sv = !bus.CWP_Ld && bus.Save && !bus.Restore;
    assign do_rs = !bus.CWP_Ld && bus.Restore && !bus.Save;

    always_comb begin
        cwp_d = cwp_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        unique case (1'b1)
            do_ld: begin
                if ({1'b0, bus.CWP_In} < 6'(NWINDOWS))
                    cwp_d = CW'(bus.CWP_In);
            end
            do_sv: begin
                if (bus.WIM_In[dec]) ovf_d = 1'b1;
                else                 cwp_d = dec;
            end
            do_rs: begin
                if (bus.WIM_In[inc]) unf_d = 1'b1;
                else                 cwp_d = inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cwp_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cwp_q <= cwp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
endmodule

// File: tb/tb_windowed_register_file.sv
// Directed bench for windowed_register_file at NWINDOWS = 3, 8 and 32.
// All three instances share stimulus; WIM only reaches the 8-window one.
module tb_windowed_register_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra, rb, rd, cin;
    logic [31:0] wd;
    logic        ld, sv, rs, cld;
    logic [7:0]  wim8;
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    windowed_register_file_if #(.NWINDOWS(3),  .DATA_W(32)) i3 ();
    windowed_register_file_if #(.NWINDOWS(8),  .DATA_W(32)) i8 ();
    windowed_register_file_if #(.NWINDOWS(32), .DATA_W(32)) i32 ();

    assign i3.RA_Sel = ra;   assign i8.RA_Sel = ra;   assign i32.RA_Sel = ra;
    assign i3.RB_Sel = rb;   assign i8.RB_Sel = rb;   assign i32.RB_Sel = rb;
    assign i3.RD_Sel = rd;   assign i8.RD_Sel = rd;   assign i32.RD_Sel = rd;
    assign i3.Wr_Data = wd;  assign i8.Wr_Data = wd;  assign i32.Wr_Data = wd;
    assign i3.RF_Ld = ld;    assign i8.RF_Ld = ld;    assign i32.RF_Ld = ld;
    assign i3.Save = sv;     assign i8.Save = sv;     assign i32.Save = sv;
    assign i3.Restore = rs;  assign i8.Restore = rs;  assign i32.Restore = rs;
    assign i3.CWP_Ld = cld;  assign i8.CWP_Ld = cld;  assign i32.CWP_Ld = cld;
    assign i3.CWP_In = cin;  assign i8.CWP_In = cin;  assign i32.CWP_In = cin;
    assign i3.WIM_In = '0;
    assign i8.WIM_In = wim8;
    assign i32.WIM_In = '0;

    windowed_register_file #(.NWINDOWS(3), .DATA_W(32)) u3 (
        .Clock(clk), .Reset(rst_n), .bus(i3)
    );
    windowed_register_file #(.NWINDOWS(8), .DATA_W(32)) u8 (
        .Clock(clk), .Reset(rst_n), .bus(i8)
    );
    windowed_register_file #(.NWINDOWS(32), .DATA_W(32)) u32 (
        .Clock(clk), .Reset(rst_n), .bus(i32)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cwp(input logic [4:0] v);
        cld = 1'b1;
        cin = v;
        step();
        cld = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
        rd = r;
        wd = v;
        ld = 1'b1;
        step();
        ld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ra = '0; rb = '0; rd = '0; cin = '0; wd = '0;
        ld = 1'b0; sv = 1'b0; rs = 1'b0; cld = 1'b0; wim8 = '0;
        #12;
        check("rst_cwp", 32'(i8.CWP), 32'd0);
        check("rst_ovf", 32'(i8.Win_Overflow), 32'd0);
        check("rst_unf", 32'(i8.Win_Underflow), 32'd0);
        rst_n = 1'b1;
        step();

        // Async reset mid-run with CWP=5 and an overflow pulse pending
        load_cwp(5'd5);
        check("ld5", 32'(i8.CWP), 32'd5);
        wim8 = 8'h10;
        sv = 1'b1;
        step();
        sv = 1'b0;
        check("pre_rst_ovf", 32'(i8.Win_Overflow), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_cwp", 32'(i8.CWP), 32'd0);
        check("async_ovf", 32'(i8.Win_Overflow), 32'd0);
        #1;
        rst_n = 1'b1;
        wim8 = '0;

        write_reg(5'd3, 32'hDEADBEEF);
        ra = 5'd3;
        #1 check("r3", i8.RA_Out, 32'hDEADBEEF);
        write_reg(5'd0, 32'h0000_1234);
        ra = 5'd0;
        rb = 5'd3;
        #1 check("r0", i8.RA_Out, 32'd0);
        check("rb_r3", i8.RB_Out, 32'hDEADBEEF);

        // Window overlap: outs of window 3 are ins of window 2
        load_cwp(5'd3);
        write_reg(5'd8, 32'hAAAA0001);
        sv = 1'b1; step(); sv = 1'b0;
        check("sv_cwp2", 32'(i8.CWP), 32'd2);
        ra = 5'd24;
        #1 check("ovl_in", i8.RA_Out, 32'hAAAA0001);
        rs = 1'b1; step(); rs = 1'b0;
        check("rs_cwp3", 32'(i8.CWP), 32'd3);
        ra = 5'd8;
        #1 check("ovl_out", i8.RA_Out, 32'hAAAA0001);

        // Wrap 0 -> 7 and the last window's ins alias window 0's outs
        load_cwp(5'd0);
        sv = 1'b1; step(); sv = 1'b0;
        check("wrap_cwp7", 32'(i8.CWP), 32'd7);
        write_reg(5'd24, 32'h55);
        rs = 1'b1; step(); rs = 1'b0;
        check("wrap_cwp0", 32'(i8.CWP), 32'd0);
        ra = 5'd8;
        #1 check("wrap_r8", i8.RA_Out, 32'h55);

        // Overflow and underflow traps
        load_cwp(5'd1);
        wim8 = 8'h01;
        sv = 1'b1; step(); sv = 1'b0;
        check("ovf_cwp", 32'(i8.CWP), 32'd1);
        check("ovf_hi", 32'(i8.Win_Overflow), 32'd1);
        step();
        check("ovf_lo", 32'(i8.Win_Overflow), 32'd0);
        load_cwp(5'd6);
        wim8 = 8'h80;
        rs = 1'b1; step(); rs = 1'b0;
        check("unf_cwp", 32'(i8.CWP), 32'd6);
        check("unf_hi", 32'(i8.Win_Underflow), 32'd1);
        step();
        check("unf_lo", 32'(i8.Win_Underflow), 32'd0);

        // Priority
        wim8 = '0;
        load_cwp(5'd4);
        sv = 1'b1; rs = 1'b1; step(); sv = 1'b0; rs = 1'b0;
        check("both_cwp", 32'(i8.CWP), 32'd4);
        check("both_ovf", 32'(i8.Win_Overflow), 32'd0);
        check("both_unf", 32'(i8.Win_Underflow), 32'd0);
        wim8 = 8'h08;
        sv = 1'b1;
        load_cwp(5'd2);
        sv = 1'b0;
        check("ldsv_cwp", 32'(i8.CWP), 32'd2);
        check("ldsv_ovf", 32'(i8.Win_Overflow), 32'd0);
        wim8 = '0;
        load_cwp(5'd4);
        load_cwp(5'd9);
        check("ld_illegal", 32'(i8.CWP), 32'd4);

        // Same-edge write and Save on all three sizes
        load_cwp(5'd1);
        write_reg(5'd16, 32'h11);
        load_cwp(5'd2);
        rd = 5'd16; wd = 32'h77; ld = 1'b1; sv = 1'b1;
        step();
        ld = 1'b0; sv = 1'b0;
        ra = 5'd16;
        #1;
        check("se3_cwp", 32'(i3.CWP), 32'd1);
        check("se8_cwp", 32'(i8.CWP), 32'd1);
        check("se32_cwp", 32'(i32.CWP), 32'd1);
        check("se3_oth", i3.RA_Out, 32'h11);
        check("se8_oth", i8.RA_Out, 32'h11);
        check("se32_oth", i32.RA_Out, 32'h11);
        rs = 1'b1; step(); rs = 1'b0;
        check("se3_r16", i3.RA_Out, 32'h77);
        check("se8_r16", i8.RA_Out, 32'h77);
        check("se32_r16", i32.RA_Out, 32'h77);

        // Wrap per size and CWP_In legality per size
        load_cwp(5'd0);
        sv = 1'b1; step(); sv = 1'b0;
        check("w3_cwp", 32'(i3.CWP), 32'd2);
        check("w32_cwp", 32'(i32.CWP), 32'd31);
        load_cwp(5'd31);
        check("ld31_32", 32'(i32.CWP), 32'd31);
        check("ld31_8", 32'(i8.CWP), 32'd7);
        load_cwp(5'd3);
        check("ld3_3", 32'(i3.CWP), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
